flappy_game_ctrl: RTL and testbench
===================================

Name: flappy_game_ctrl

Overview:
Top-level game sequencer for the Flappy Bird datapath. It debounces the flap button and runs the IDLE/PLAY/DYING/OVER state machine. It issues the restart pulse and run enable to the bird physics and pipe logic, and converts the button into flap pulses. It owns the current score and the session high score that feed the text renderer.

Parameters:
DEBOUNCE_CYC, 250000, number of consecutive clk cycles the synced button must hold a new level before it is accepted
RST_PULSE, 4, length in clk cycles of the game_rst pulse on each (re)start
DYING_FRAMES, 30, frame_tick count spent in DYING before OVER
LOCK_FRAMES, 60, frame_tick count in OVER during which presses are ignored
SCORE_MAX, 9999, saturation value of score

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_raw  in  1  raw, asynchronous flap button
frame_tick  in  1  one-cycle pulse once per video frame
alive  in  1  bird alive flag from physics; valid 1 cycle after game_rst deasserts
pipe_passed  in  1  one-cycle pulse when a pipe is cleared
game_rst  out  1  synchronous restart to physics and pipes
run_enable  out  1  advance pipes and physics
flap  out  1  one-cycle flap pulse to physics
state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER
show_title  out  1  high in IDLE
show_game_over  out  1  high in OVER
new_best  out  1  high in DYING and OVER when this run set a new high score
score  out  16  current score, binary
high_score  out  16  best score since reset, binary

Behaviour:
- Reset is asynchronous, active-high, on clk. All outputs are 0 and state is IDLE. The synchroniser, debounce counter and all internal counters are cleared. high_score is also cleared.
- Button path: btn_raw passes through a 2-flop synchroniser, then a debouncer. The debounced level changes only after the synced value differs from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
- press is a one-cycle rising edge of the debounced level.
- All outputs are registered.
- Start, from IDLE or from unlocked OVER: a press sets the following on the next cycle:
  - state=PLAY
  - score=0
  - new_best=0
  - game_rst=1, held for RST_PULSE cycles
  - run_enable=0
- In the cycle after game_rst falls, run_enable=1 and a single flap pulse is emitted. This is the start flap.
- PLAY:
  - Each press outside the game_rst window produces flap=1 exactly 1 cycle later, lasting 1 cycle.
  - A press during the game_rst window is dropped.
  - pipe_passed with alive=1 and game_rst=0 increments score, saturating at SCORE_MAX.
  - alive=0 sampled while game_rst=0 and run_enable=1 moves to DYING on the next cycle.
- Simultaneous events in the alive-drop cycle: a pipe_passed is not counted, because alive=0. A press produces no flap.
- Entering DYING:
  - run_enable=0 and flap is held at 0.
  - The frame counter clears.
  - If score > high_score, high_score<=score and new_best<=1. An equal score does not update.
- DYING: presses are ignored. After DYING_FRAMES frame_ticks, the next cycle enters OVER and the counter clears.
- OVER:
  - show_game_over=1 and run_enable=0.
  - Presses are ignored until LOCK_FRAMES frame_ticks have been counted.
  - After that, a press restarts exactly as from IDLE.
  - A press that is still held from the lock period does not count; only a new rising edge restarts.
- The score holds its value through DYING and OVER.
- frame_tick and press arriving in the same cycle: the tick is counted first. If it completes the lock, that press is still ignored.
- An asynchronous reset mid-game returns to IDLE immediately, with no game_rst pulse.

Test Plan:
1. DEBOUNCE_CYC=8; btn_raw bounces 3 cycles high, 2 low, then holds high 20 cycles -> exactly one press; flap appears 0 times in IDLE; state goes to PLAY once.
2. Start from IDLE -> game_rst high exactly 4 cycles, run_enable rises in the following cycle together with a single flap, and score=0.
3. In PLAY, 12 pipe_passed pulses with alive=1, then 1 pulse with alive=0 -> score=12. With SCORE_MAX=5, 8 pulses -> score=5.
4. alive drops with score=7 and high_score=3 -> DYING next cycle, high_score=7, new_best=1. After 30 frame_ticks state=3. A second run dying with score=7 leaves new_best=0.
5. In OVER, press at tick 10 -> ignored. Press at tick 60 in the same cycle as the 60th tick -> ignored. Press after that -> PLAY with score=0 and high_score kept.
6. Assert reset during PLAY with score=4 and high_score=9 -> next cycle state=0, score=0, high_score=0, all control outputs 0.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: button debounce, IDLE/PLAY/DYING/OVER control,
// restart/run/flap generation and score bookkeeping.
module flappy_game_ctrl #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int RST_PULSE    = 4,
    parameter int DYING_FRAMES = 30,
    parameter int LOCK_FRAMES  = 60,
    parameter int SCORE_MAX    = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic        frame_tick,
    input  logic        alive,
    input  logic        pipe_passed,
    output logic        game_rst,
    output logic        run_enable,
    output logic        flap,
    output logic [1:0]  state,
    output logic        show_title,
    output logic        show_game_over,
    output logic        new_best,
    output logic [15:0] score,
    output logic [15:0] high_score
);
    localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW   = $clog2(RST_PULSE + 1);
    localparam int FMAX = (DYING_FRAMES > LOCK_FRAMES) ? DYING_FRAMES : LOCK_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t        st;
    logic          sync_meta;
    logic          sync_q;
    logic          deb_level;
    logic          deb_prev;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rst_cnt;
    logic [FW-1:0] frame_cnt;
    logic          lock_done;
    logic          press;
    logic          start;

    assign state = st;
    assign press = deb_level & ~deb_prev;
    // lock_done is the registered value, so a press landing on the final lock tick is still ignored
    assign start = press & ((st == IDLE) | ((st == OVER) & lock_done));

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // Debouncer: accept a new level after DEBOUNCE_CYC consecutive differing cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= {DW{1'b0}};
        end else begin
            deb_prev <= deb_level;
            if (sync_q != deb_level) begin
                if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                    deb_level <= sync_q;
                    deb_cnt   <= {DW{1'b0}};
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= {DW{1'b0}};
            end
        end
    end

    // Game state machine with registered control outputs and score tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st             <= IDLE;
            game_rst       <= 1'b0;
            run_enable     <= 1'b0;
            flap           <= 1'b0;
            show_title     <= 1'b0;
            show_game_over <= 1'b0;
            new_best       <= 1'b0;
            score          <= 16'd0;
            high_score     <= 16'd0;
            rst_cnt        <= {RW{1'b0}};
            frame_cnt      <= {FW{1'b0}};
            lock_done      <= 1'b0;
        end else begin
            flap <= 1'b0;
            if (start) begin
                st             <= PLAY;
                score          <= 16'd0;
                new_best       <= 1'b0;
                game_rst       <= 1'b1;
                rst_cnt        <= {RW{1'b0}};
                run_enable     <= 1'b0;
                show_title     <= 1'b0;
                show_game_over <= 1'b0;
                frame_cnt      <= {FW{1'b0}};
                lock_done      <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        show_title <= 1'b1;
                    end
                    PLAY: begin
                        if (game_rst) begin
                            // Restart window: presses and pipes are dropped; release with the start flap
                            if (rst_cnt == RW'(RST_PULSE - 1)) begin
                                game_rst   <= 1'b0;
                                run_enable <= 1'b1;
                                flap       <= 1'b1;
                            end else begin
                                rst_cnt <= rst_cnt + RW'(1);
                            end
                        end else if (run_enable && !alive) begin
                            st         <= DYING;
                            run_enable <= 1'b0;
                            frame_cnt  <= {FW{1'b0}};
                            if (score > high_score) begin
                                high_score <= score;
                                new_best   <= 1'b1;
                            end
                        end else begin
                            if (press) begin
                                flap <= 1'b1;
                            end
                            if (pipe_passed && alive && (score < 16'(SCORE_MAX))) begin
                                score <= score + 16'd1;
                            end
                        end
                    end
                    DYING: begin
                        if (frame_tick) begin
                            if (frame_cnt == FW'(DYING_FRAMES - 1)) begin
                                st             <= OVER;
                                frame_cnt      <= {FW{1'b0}};
                                lock_done      <= 1'b0;
                                show_game_over <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + FW'(1);
                            end
                        end
                    end
                    OVER: begin
                        if (frame_tick && !lock_done) begin
                            if (frame_cnt == FW'(LOCK_FRAMES - 1)) begin
                                lock_done <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + FW'(1);
                            end
                        end
                    end
                    default: begin
                        st <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with a short debounce; a second instance
// with SCORE_MAX=5 shares the stimulus to cover score saturation.
module tb_flappy_game_ctrl;
    logic        clk = 1'b0;
    logic        reset, btn_raw, frame_tick, alive, pipe_passed;
    logic        game_rst, run_enable, flap, show_title, show_game_over, new_best;
    logic [1:0]  state;
    logic [15:0] score, high_score;
    logic        s_game_rst, s_run_enable, s_flap, s_show_title, s_show_game_over, s_new_best;
    logic [1:0]  s_state;
    logic [15:0] s_score, s_high_score;

    int n_cmp = 0;
    int n_bad = 0;
    int n_grst, n_flap, n_rise, n_start, idle_flap;
    logic rise_flap, rise_prev_grst;
    logic prev_run, prev_grst;
    logic [1:0] prev_state;

    flappy_game_ctrl #(.DEBOUNCE_CYC(8)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .frame_tick(frame_tick),
        .alive(alive), .pipe_passed(pipe_passed), .game_rst(game_rst),
        .run_enable(run_enable), .flap(flap), .state(state), .show_title(show_title),
        .show_game_over(show_game_over), .new_best(new_best), .score(score),
        .high_score(high_score)
    );

    flappy_game_ctrl #(.DEBOUNCE_CYC(8), .SCORE_MAX(5)) dut_sat (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .frame_tick(frame_tick),
        .alive(alive), .pipe_passed(pipe_passed), .game_rst(s_game_rst),
        .run_enable(s_run_enable), .flap(s_flap), .state(s_state), .show_title(s_show_title),
        .show_game_over(s_show_game_over), .new_best(s_new_best), .score(s_score),
        .high_score(s_high_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (flap && state == 2'd0) idle_flap++;
            if (flap) n_flap++;
            if (game_rst) n_grst++;
            if (run_enable && !prev_run) begin
                n_rise++;
                rise_flap      = flap;
                rise_prev_grst = prev_grst;
            end
            if (state == 2'd1 && prev_state == 2'd0) n_start++;
            prev_run   = run_enable;
            prev_grst  = game_rst;
            prev_state = state;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1; step(1);
            frame_tick = 1'b0; step(1);
        end
    endtask

    task automatic pipes(input int n);
        repeat (n) begin
            pipe_passed = 1'b1; step(1);
            pipe_passed = 1'b0; step(1);
        end
    endtask

    task automatic start_game(input string tag);
        btn_raw = 1'b1;
        step(11);
        chk({tag, "_state"}, 16'(state), 16'd1);
        chk({tag, "_grst"}, 16'(game_rst), 16'd1);
        chk({tag, "_score0"}, score, 16'd0);
        chk({tag, "_nbest0"}, 16'(new_best), 16'd0);
        chk({tag, "_run0"}, 16'(run_enable), 16'd0);
        btn_raw = 1'b0;
        step(3);
        chk({tag, "_grst4"}, 16'(game_rst), 16'd1);
        step(1);
        chk({tag, "_grst_off"}, 16'(game_rst), 16'd0);
        chk({tag, "_run1"}, 16'(run_enable), 16'd1);
        chk({tag, "_sflap"}, 16'(flap), 16'd1);
        step(1);
        chk({tag, "_sflap_end"}, 16'(flap), 16'd0);
        step(12);
    endtask

    task automatic die(input string tag);
        pipe_passed = 1'b1;
        alive       = 1'b0;
        step(1);
        pipe_passed = 1'b0;
        alive       = 1'b1;
        chk({tag, "_dying"}, 16'(state), 16'd2);
        chk({tag, "_run_off"}, 16'(run_enable), 16'd0);
    endtask

    initial begin
        reset = 1'b1; btn_raw = 1'b0; frame_tick = 1'b0; alive = 1'b1; pipe_passed = 1'b0;
        prev_run = 1'b0; prev_grst = 1'b0; prev_state = 2'd0;
        step(2);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_outs", 16'({game_rst, run_enable, flap, show_title, show_game_over, new_best}), 16'd0);
        chk("rst_high", high_score, 16'd0);
        reset = 1'b0;
        step(1);
        chk("idle_title", 16'(show_title), 16'd1);

        // Bouncy button then a clean hold: exactly one start
        n_grst = 0; n_flap = 0; n_rise = 0; n_start = 0; idle_flap = 0;
        btn_raw = 1'b1; step(3);
        btn_raw = 1'b0; step(2);
        btn_raw = 1'b1; step(20);
        chk("t1_starts", 16'(n_start), 16'd1);
        chk("t1_idle_flap", 16'(idle_flap), 16'd0);
        chk("t1_state", 16'(state), 16'd1);
        btn_raw = 1'b0; step(12);
        chk("t2_grst_len", 16'(n_grst), 16'd4);
        chk("t2_rises", 16'(n_rise), 16'd1);
        chk("t2_flaps", 16'(n_flap), 16'd1);
        chk("t2_rise_flap", 16'(rise_flap), 16'd1);
        chk("t2_rise_after_grst", 16'(rise_prev_grst), 16'd1);
        chk("t2_score", score, 16'd0);

        // Flap on press during play
        btn_raw = 1'b1; step(10);
        chk("flap_early", 16'(flap), 16'd0);
        step(1);
        chk("flap_on", 16'(flap), 16'd1);
        step(1);
        chk("flap_off", 16'(flap), 16'd0);
        btn_raw = 1'b0; step(12);

        // Run 1: score 3 then death
        pipes(3);
        chk("r1_score", score, 16'd3);
        die("r1");
        chk("r1_score_hold", score, 16'd3);
        chk("r1_high", high_score, 16'd3);
        chk("r1_nbest", 16'(new_best), 16'd1);
        ticks(29);
        chk("r1_still_dying", 16'(state), 16'd2);
        ticks(1);
        chk("r1_over", 16'(state), 16'd3);
        chk("r1_gover", 16'(show_game_over), 16'd1);
        chk("r1_nbest_over", 16'(new_best), 16'd1);

        // Lockout: press at tick 10 ignored, press on the 60th tick ignored
        ticks(10);
        btn_raw = 1'b1; step(11);
        chk("lock_press10", 16'(state), 16'd3);
        btn_raw = 1'b0; step(12);
        ticks(49);
        btn_raw = 1'b1; step(10);
        frame_tick = 1'b1; step(1);
        frame_tick = 1'b0;
        chk("lock_press60", 16'(state), 16'd3);
        btn_raw = 1'b0; step(12);
        chk("lock_held", 16'(state), 16'd3);
        start_game("r2");
        chk("r2_high_kept", high_score, 16'd3);

        // Run 2: saturation on the second instance, new best 12
        pipes(8);
        chk("r2_score8", score, 16'd8);
        chk("sat_score", s_score, 16'd5);
        pipes(4);
        chk("r2_score12", score, 16'd12);
        chk("sat_score_hold", s_score, 16'd5);
        die("r2");
        chk("r2_score_hold", score, 16'd12);
        chk("r2_high", high_score, 16'd12);
        chk("r2_nbest", 16'(new_best), 16'd1);
        chk("sat_high", s_high_score, 16'd5);
        ticks(30);
        ticks(60);
        start_game("r3");

        // Run 3: equal score is not a new best
        pipes(12);
        die("r3");
        chk("r3_high", high_score, 16'd12);
        chk("r3_nbest", 16'(new_best), 16'd0);
        ticks(30);
        chk("r3_over", 16'(state), 16'd3);
        ticks(60);
        start_game("r4");

        // Asynchronous reset mid-game
        pipes(4);
        chk("r4_score", score, 16'd4);
        reset = 1'b1;
        #1;
        chk("ar_state", 16'(state), 16'd0);
        chk("ar_score", score, 16'd0);
        chk("ar_high", high_score, 16'd0);
        chk("ar_outs", 16'({game_rst, run_enable, flap, show_title, show_game_over, new_best}), 16'd0);
        step(2);
        reset = 1'b0;
        step(2);
        chk("ar_idle", 16'(state), 16'd0);
        chk("ar_no_grst", 16'(game_rst), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
